// File: rtl/if_pkg.sv
// Fetch-stage shared types and constants: bus widths, ROM enable levels,
// the {pc, inst} queue entry and the default reset PC.
package if_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;

  localparam logic [INST_W-1:0]      ZERO_WORD        = '0;
  localparam logic [INST_ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {pc, inst} pairs with a flush that
// discards everything queued; the head reads as zero when empty.
module fetch_queue
  import if_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               push,
  input  fetch_entry_t       push_data,
  input  logic               pop,
  output fetch_entry_t       head,
  output logic [CNT_W-1:0]   count,
  output logic               full
);

  fetch_entry_t           mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic                   empty;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: storage has no reset; an empty count already hides stale entries.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch initiator: owns the PC, drives the combinational ROM,
// queues fetched words for decode and handles redirects from execute.
module inst_fetch
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
);

  localparam int CNT_W = $clog2(QDEPTH) + 1;

  logic               running;
  logic [31:0]        pc;
  logic               fetch;
  logic               q_full;
  logic [CNT_W-1:0]   q_count;
  fetch_entry_t       q_head;
  fetch_entry_t       q_push_data;

  // Fetch is gated only by queue space, never by out_ready, so a full
  // queue that drains this cycle still costs one bubble.
  assign fetch    = running && !q_full && !redirect_valid;
  assign rom_ce   = fetch ? CHIP_ENABLE : CHIP_DISABLE;
  assign rom_addr = pc;

  assign q_push_data = '{pc: pc, inst: rom_inst};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      pc      <= RESET_PC & ~32'h3;
    end else begin
      running <= 1'b1;
      if (redirect_valid) pc <= redirect_pc & ~32'h3;
      else if (fetch)     pc <= pc + 32'd4;
    end
  end

  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (fetch),
    .push_data (q_push_data),
    .pop       (out_valid && out_ready),
    .head      (q_head),
    .count     (q_count),
    .full      (q_full)
  );

  assign out_valid = (q_count != '0);
  assign out_pc    = q_head.pc;
  assign out_inst  = q_head.inst;

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch initiator that drives the chip-enable/address side of the combinational instruction ROM and captures the returned word.
- Keeps the PC, issues one sequential fetch per cycle, and buffers {pc, inst} pairs in a small FIFO.
- Presents buffered pairs to decode over a valid/ready handshake.
- Accepts branch/jump redirects from later stages and flushes wrong-path fetches.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
QDEPTH, 2, fetch-queue entries (power of 2, ≥2)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
rom_ce  out  1  ROM chip enable (`ChipEnable when fetching)
rom_addr  out  32  byte address to ROM, bits [1:0] always 0
rom_inst  in  32  ROM data, combinational in the same cycle as rom_addr
redirect_valid  in  1  redirect request from execute
redirect_pc  in  32  redirect target
out_valid  out  1  head entry valid to decode
out_ready  in  1  decode accepts head entry
out_pc  out  32  PC of head entry
out_inst  out  32  instruction of head entry

Behaviour:
- Reset (rst_n low, asynchronous):
  - pc=RESET_PC; queue empty (count=0, rd/wr pointers 0).
  - rom_ce=`ChipDisable, out_valid=0, out_pc=0, out_inst=`ZeroWord.
  - Same values hold while rst_n is low, including reset asserted mid-stream. Queue contents are discarded.
- rom_ce = `ChipEnable iff out of reset (registered flag set on the first clk edge after rst_n rises), count<QDEPTH, and redirect_valid=0.
  - rom_ce is not a function of out_ready.
- rom_addr = pc (combinational). With rom_ce low, rom_addr still shows pc. rom_inst is ignored.
- Fetch cycle (rom_ce high): {pc, rom_inst} is written at wr_ptr, count increments, pc<=pc+4.
  - 32-bit add wraps: 32'hFFFF_FFFC → 0.
- Dequeue: when out_valid && out_ready, rd_ptr advances and count decrements.
  - Enqueue and dequeue in the same cycle leave count unchanged.
  - A full queue with a dequeue does not fetch that cycle; fetch resumes next cycle, giving 1 bubble.
- out_valid = (count!=0). out_pc/out_inst are the head entry, combinational from the storage array. Output is 0 when empty.
- Redirect (redirect_valid high):
  - Queue flushed: count<=0 and pointers reset. Any dequeue handshake in that cycle is still treated as consumed, with no effect after the flush.
  - pc <= {redirect_pc[31:2],2'b00}. No fetch occurs that cycle.
  - Target is fetched the next cycle. The target appears on out_valid 2 cycles after redirect asserts: fetch in cycle +1, visible in cycle +1 after enqueue, i.e. out_valid high in the cycle following the fetch edge.
- Back-to-back redirects: the last one wins. Each flushes.
- Latency, empty queue, no stall: fetch at cycle N, out_valid in N+1.
- Steady-state throughput with out_ready=1: 1 instr/cycle for QDEPTH≥2.
- No pointer or count overflow: count width = $clog2(QDEPTH)+1. Writes occur only when count<QDEPTH.

Decomposition:
- Shared defines (existing defines.svh): `InstAddrBus, `InstBus, `ZeroWord, `ChipEnable/`ChipDisable.
- Add to it: fetch entry struct type (pc, inst) in a fetch package (if_pkg) and the RESET_PC default constant.
- One sub-module: fetch_queue, a synchronous FIFO with flush, push/pop, full/empty, and count.
- inst_fetch holds the PC, ce logic, and redirect handling.

Test Plan:
- Reset release, RESET_PC=0, out_ready=1: rom_ce high from the first edge. rom_addr is 0,4,8,… each cycle. out_pc follows one cycle behind with matching out_inst.
- out_ready=0 held for 5 cycles: exactly QDEPTH=2 fetches (addr 0,4), then rom_ce=0 with rom_addr stuck at 8. On out_ready=1, the entries drain in order 0,4, then 8 is fetched.
- redirect_valid pulse with redirect_pc=32'h100 while the queue holds 2 entries: out_valid=0 next cycle. Next fetch addr 0x100; out_pc=0x100 appears. No stale entries ever handshake.
- redirect_pc=32'h203 → fetch addr 0x200. Two consecutive redirects 0x40 then 0x80 → only 0x80 is fetched.
- PC wrap: redirect to 32'hFFFF_FFFC → fetches 0xFFFF_FFFC then 0x0.
- rst_n asserted mid-stream with the queue full: out_valid and rom_ce drop immediately (asynchronously). After release, fetching restarts at RESET_PC.
